// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: latches register-file reads and decode fields, bypasses the
// write-back port into the capture, forwards EX/MEM and MEM/WB, and detects load-use.
module id_ex_operand_stage #(
   parameter int DATA_W = 32,
   parameter int AW     = 5,
   parameter int CTRL_W = 8
) (
   input  logic              Clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [AW-1:0]     id_rs,
   input  logic [AW-1:0]     id_rt,
   input  logic [AW-1:0]     id_rd,
   input  logic [DATA_W-1:0] busX,
   input  logic [DATA_W-1:0] busY,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              exm_valid,
   input  logic              exm_regwrite,
   input  logic [AW-1:0]     exm_rd,
   input  logic [DATA_W-1:0] exm_result,
   input  logic              wb_regwrite,
   input  logic [AW-1:0]     wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   output logic              ex_valid,
   output logic [AW-1:0]     ex_rs,
   output logic [AW-1:0]     ex_rt,
   output logic [AW-1:0]     ex_rd,
   output logic [DATA_W-1:0] ex_opA,
   output logic [DATA_W-1:0] ex_opB,
   output logic [DATA_W-1:0] ex_imm,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic              ex_regwrite,
   output logic              ex_memread,
   output logic              load_use_stall
);

   logic              r_valid;
   logic [AW-1:0]     r_rs, r_rt, r_rd;
   logic [DATA_W-1:0] r_rs_val, r_rt_val, r_imm;
   logic [CTRL_W-1:0] r_ctrl;
   logic              r_regwrite, r_memread;

   logic              w_wbhit_id_rs, w_wbhit_id_rt;
   logic              w_wbhit_ex_rs, w_wbhit_ex_rt;
   logic              w_exmhit_ex_rs, w_exmhit_ex_rt;
   logic [DATA_W-1:0] w_cap_rs, w_cap_rt;
   logic              w_lus;

   function automatic logic f_hit(input logic we, input logic [AW-1:0] wr,
                                  input logic [AW-1:0] r);
      return we & (wr != '0) & (wr == r);
   endfunction

   assign w_wbhit_id_rs  = f_hit(wb_regwrite, wb_rd, id_rs);
   assign w_wbhit_id_rt  = f_hit(wb_regwrite, wb_rd, id_rt);
   assign w_wbhit_ex_rs  = f_hit(wb_regwrite, wb_rd, r_rs);
   assign w_wbhit_ex_rt  = f_hit(wb_regwrite, wb_rd, r_rt);
   assign w_exmhit_ex_rs = f_hit(exm_valid & exm_regwrite, exm_rd, r_rs);
   assign w_exmhit_ex_rt = f_hit(exm_valid & exm_regwrite, exm_rd, r_rt);

   // The register file does not bypass its own write port, so the same-cycle
   // write is folded in here before the value is latched.
   assign w_cap_rs = (id_rs == '0) ? '0 : (w_wbhit_id_rs ? wb_data : busX);
   assign w_cap_rt = (id_rt == '0) ? '0 : (w_wbhit_id_rt ? wb_data : busY);

   assign w_lus = r_valid & r_memread & (r_rd != '0) & id_valid &
                  ((r_rd == id_rs) | (r_rd == id_rt));

   always_ff @(posedge Clk or negedge rst) begin
      if (!rst) begin
         r_valid    <= 1'b0;
         r_rs       <= '0;
         r_rt       <= '0;
         r_rd       <= '0;
         r_rs_val   <= '0;
         r_rt_val   <= '0;
         r_imm      <= '0;
         r_ctrl     <= '0;
         r_regwrite <= 1'b0;
         r_memread  <= 1'b0;
      end else if (flush) begin
         r_valid    <= 1'b0;
         r_regwrite <= 1'b0;
         r_memread  <= 1'b0;
      end else if (stall) begin
         // A value forwarded earlier may commit while we wait; latch it now.
         if (w_wbhit_ex_rs) r_rs_val <= wb_data;
         if (w_wbhit_ex_rt) r_rt_val <= wb_data;
      end else if (w_lus) begin
         r_valid    <= 1'b0;
         r_regwrite <= 1'b0;
         r_memread  <= 1'b0;
      end else begin
         r_valid    <= id_valid;
         r_rs       <= id_rs;
         r_rt       <= id_rt;
         r_rd       <= id_rd;
         r_rs_val   <= w_cap_rs;
         r_rt_val   <= w_cap_rt;
         r_imm      <= id_imm;
         r_ctrl     <= id_ctrl;
         r_regwrite <= id_regwrite;
         r_memread  <= id_memread;
      end
   end

   // EX/MEM is the younger producer, so it wins over WB.
   assign ex_opA = w_exmhit_ex_rs ? exm_result : (w_wbhit_ex_rs ? wb_data : r_rs_val);
   assign ex_opB = w_exmhit_ex_rt ? exm_result : (w_wbhit_ex_rt ? wb_data : r_rt_val);

   assign ex_valid       = r_valid;
   assign ex_rs          = r_rs;
   assign ex_rt          = r_rt;
   assign ex_rd          = r_rd;
   assign ex_imm         = r_imm;
   assign ex_ctrl        = r_ctrl;
   assign ex_regwrite    = r_valid & r_regwrite;
   assign ex_memread     = r_valid & r_memread;
   assign load_use_stall = w_lus;

endmodule
